// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: shared types and defaults for the SRAM responder slice.
//   state_e : responder FSM states (WAIT only reachable with SRAM_RESP_DELAY_EN)
//   port_e  : which requester owns the outstanding transaction
//   DEPTH_LOG2_DEF / DELAY_DEF : parameter defaults for sram_responder
package sram_resp_pkg;

    localparam int DEPTH_LOG2_DEF = 10;
    localparam int DELAY_DEF      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: instruction + data request/response bus of the SRAM responder.
//   inst_*  : read-only instruction port (req/addr in, addr_ok/data_ok/rdata out)
//   data_*  : read/write data port (req/wr/wstrb/addr/wdata in, addr_ok/data_ok/rdata out)
//   master  : requester side (drives req, addr, write payload)
//   slave   : responder side (drives addr_ok, data_ok, rdata)
interface sram_responder_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/sram_resp_mem.sv
// sram_resp_mem: 2^DEPTH_LOG2 x 32-bit word array.
//   clk              : clock
//   we_i/wstrb_i     : write enable and per-byte strobes (bit i = byte i)
//   waddr_i/wdata_i  : write word index and data
//   re_i/raddr_i     : read enable and word index; data appears on rdata_o next cycle
//   rdata_o          : latched read data, held until the next read
// Contents are never reset.
module sram_resp_mem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [3:0]            wstrb_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: single-outstanding SRAM model serving an instruction and a data port.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any transaction, memory is kept
//   bus   : sram_responder_if.slave (inst_* read port, data_* read/write port)
// Flow: IDLE (grant + capture, write commits here) -> ACCESS (array read)
//       -> [WAIT] -> RESP (data_ok one cycle) -> IDLE. Data port wins ties.
// Optional: `define SRAM_RESP_DELAY_EN adds a WAIT state of DELAY cycles.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DELAY      = DELAY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    sram_responder_if.slave  bus
);

    if (DELAY < 0) begin : g_bad_delay
        $error("sram_responder: DELAY must be >= 0");
    end

    state_e                state_q;
    port_e                 port_q;
    logic                  wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;

`ifdef SRAM_RESP_DELAY_EN
    localparam int CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    logic [CW-1:0] cnt_q;
`endif

    logic                  grant_data;
    logic                  grant_inst;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [31:0]           rd_data;
    logic                  resp_live;
    logic                  unused_addr_bits;

    // Grants are gated by reset so nothing is acknowledged while reset is high.
    assign grant_data = !reset && (state_q == IDLE) && bus.data_req;
    assign grant_inst = !reset && (state_q == IDLE) && !bus.data_req && bus.inst_req;

    assign req_idx = bus.data_req ? bus.data_addr[DEPTH_LOG2+1:2]
                                  : bus.inst_addr[DEPTH_LOG2+1:2];

    assign unused_addr_bits = ^{bus.inst_addr[31:DEPTH_LOG2+2], bus.inst_addr[1:0],
                                bus.data_addr[31:DEPTH_LOG2+2], bus.data_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        state_q <= ACCESS;
                        port_q  <= grant_data ? PORT_DATA : PORT_INST;
                        wr_q    <= grant_data && bus.data_wr;
                        idx_q   <= req_idx;
                    end
                end
                ACCESS: begin
`ifdef SRAM_RESP_DELAY_EN
                    if (DELAY > 0) begin
                        state_q <= WAIT;
                        cnt_q   <= CW'(DELAY);
                    end else begin
                        state_q <= RESP;
                    end
`else
                    state_q <= RESP;
`endif
                end
`ifdef SRAM_RESP_DELAY_EN
                WAIT: begin
                    // Leave on the last of DELAY wait cycles.
                    if (cnt_q == CW'(1)) state_q <= RESP;
                    cnt_q <= cnt_q - CW'(1);
                end
`endif
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write commits on the capture edge; read happens during ACCESS and is
    // held by the memory until the response.
    sram_resp_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .we_i    (grant_data && bus.data_wr),
        .wstrb_i (bus.data_wstrb),
        .waddr_i (bus.data_addr[DEPTH_LOG2+1:2]),
        .wdata_i (bus.data_wdata),
        .re_i    (state_q == ACCESS),
        .raddr_i (idx_q),
        .rdata_o (rd_data)
    );

    assign resp_live = !reset && (state_q == RESP);

    assign bus.data_addr_ok = grant_data;
    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_data_ok = resp_live && (port_q == PORT_DATA);
    assign bus.inst_data_ok = resp_live && (port_q == PORT_INST);
    assign bus.data_rdata   = (bus.data_data_ok && !wr_q) ? rd_data : 32'h0;
    assign bus.inst_rdata   = bus.inst_data_ok ? rd_data : 32'h0;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed scoreboard bench for sram_responder.
// Stimulus pushes expected responses (port, rdata, cycle) into a queue; a
// negedge monitor pops and compares whenever a data_ok appears.
module tb_sram_responder;

`ifdef SRAM_RESP_DELAY_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    sram_responder_if bus ();

    sram_responder #(.DEPTH_LOG2(10), .DELAY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_resp(input bit is_data, input logic [31:0] rd);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_data_ok: port_data=%0d rdata=%h at cycle %0d, none expected",
                     is_data, rd, cyc);
        end else begin
            e = sb.pop_front();
            if (e.is_data != is_data || rd !== e.rdata || cyc != e.cyc) begin
                bad++;
                $display("FAIL %s: got port_data=%0d rdata=%h cycle=%0d, want port_data=%0d rdata=%h cycle=%0d",
                         e.name, is_data, rd, cyc, e.is_data, e.rdata, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_data_ok) check_resp(1'b1, bus.data_rdata);
            if (bus.inst_data_ok) check_resp(1'b0, bus.inst_rdata);
        end
    end

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
    endtask

    task automatic check_outs_zero(input string nm);
        total++;
        if (bus.inst_addr_ok || bus.inst_data_ok || bus.data_addr_ok || bus.data_data_ok ||
            bus.inst_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin
            bad++;
            $display("FAIL %s: got aok i/d=%b%b dok i/d=%b%b irdata=%h drdata=%h, want all 0",
                     nm, bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok,
                     bus.data_data_ok, bus.inst_rdata, bus.data_rdata);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle: addr_ok must show up immediately.
    task automatic issue(input bit is_data, input bit wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input string nm, input bit push);
        int n = 0;
        exp_t e;
        if (is_data) begin
            bus.data_req = 1'b1; bus.data_wr = wr; bus.data_wstrb = strb;
            bus.data_addr = addr; bus.data_wdata = wdata;
        end else begin
            bus.inst_req = 1'b1; bus.inst_addr = addr;
        end
        @(negedge clk);
        while (!(is_data ? bus.data_addr_ok : bus.inst_addr_ok) && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL %s_addr_ok: got addr_ok after %0d extra cycles, want 0", nm, n);
        end
        if (push) begin
            e.is_data = is_data; e.rdata = exp_rd; e.cyc = cyc + LAT; e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Returns at posedge+1 of the IDLE cycle after the last response.
    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d responses outstanding, want 0", nm, sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        int   n;
        int   g;
        exp_t e;

        idle_inputs();
        reset = 1'b1;
        bus.data_req = 1'b1;
        bus.inst_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset_outputs");
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read back.
        issue(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, "wr_full", 1);
        drain("wr_full");
        issue(1, 0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "rd_full", 1);
        drain("rd_full");

        // Partial write merges into existing word.
        issue(1, 1, 4'hF, 32'h20, 32'h11223344, 32'h0, "wr_base", 1);
        drain("wr_base");
        issue(1, 1, 4'h2, 32'h20, 32'h0000AA00, 32'h0, "wr_part", 1);
        drain("wr_part");
        issue(1, 0, 4'h0, 32'h20, 32'h0, 32'h1122AA44, "rd_part", 1);
        drain("rd_part");

        // Zero strobe still answers, memory untouched; low addr bits ignored.
        issue(1, 1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, "wr_nostrb", 1);
        drain("wr_nostrb");
        issue(1, 0, 4'h0, 32'h13, 32'h0, 32'hDEADBEEF, "rd_nostrb", 1);
        drain("rd_nostrb");

        // Address wrap-around at 2^10 words.
        issue(1, 1, 4'hF, 32'h0000_1000, 32'h55, 32'h0, "wr_wrap", 1);
        drain("wr_wrap");
        issue(1, 0, 4'h0, 32'h0, 32'h0, 32'h55, "rd_wrap", 1);
        drain("rd_wrap");

        // Instruction port read.
        issue(0, 0, 4'h0, 32'h20, 32'h0, 32'h1122AA44, "inst_rd", 1);
        drain("inst_rd");

        // Simultaneous requests: data wins, inst granted the IDLE after data_ok.
        bus.data_req = 1'b1; bus.data_addr = 32'h10;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0;
        @(negedge clk);
        total++;
        if (!(bus.data_addr_ok && !bus.inst_addr_ok)) begin
            bad++;
            $display("FAIL arb_grant: got data_aok=%b inst_aok=%b, want 1 0",
                     bus.data_addr_ok, bus.inst_addr_ok);
        end
        g = cyc;
        e.is_data = 1; e.rdata = 32'hDEADBEEF; e.cyc = g + LAT; e.name = "arb_data";
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.data_req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.inst_addr_ok && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!bus.inst_addr_ok || cyc != g + LAT + 1) begin
            bad++;
            $display("FAIL arb_inst_grant: got inst_aok=%b at cycle %0d, want 1 at cycle %0d",
                     bus.inst_addr_ok, cyc, g + LAT + 1);
        end
        e.is_data = 0; e.rdata = 32'h55; e.cyc = cyc + LAT; e.name = "arb_inst";
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        drain("arb");

        // Reset during ACCESS of a read: no response, outputs 0.
        issue(1, 0, 4'h0, 32'h20, 32'h0, 32'h0, "abort_rd", 0);
        reset = 1'b1;
        @(negedge clk);
        check_outs_zero("abort_rd_outputs");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        issue(1, 0, 4'h0, 32'h20, 32'h0, 32'h1122AA44, "rd_after_abort", 1);
        drain("rd_after_abort");

        // Reset during ACCESS of a write: write is already committed.
        issue(1, 1, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0, "abort_wr", 0);
        reset = 1'b1;
        @(negedge clk);
        check_outs_zero("abort_wr_outputs");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        issue(1, 0, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, "rd_committed", 1);
        drain("rd_committed");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
